// File: rtl/wall_query_engine.sv
// Round-robin shared wall lookup: one mover per 2 cycles, registered results.
// Optional WALLQ_WRAP_EN enables horizontal tunnel wrap at map edges.
module wall_query_engine #(
  parameter int MAP_W      = 16,
  parameter int MAP_H      = 24,
  parameter int TILE_SHIFT = 4,
  parameter int NUM_CH     = 4,
  parameter int POS_W      = 10
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [MAP_W*MAP_H-1:0]  wallData,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*POS_W-1:0] xPos,
  input  logic [NUM_CH*POS_W-1:0] yPos,
  output logic [NUM_CH-1:0]       ack,
  output logic [NUM_CH*4-1:0]     walls,
  output logic [NUM_CH-1:0]       oob,
  output logic                    busy
);

  localparam int CELLS = MAP_W * MAP_H;
  localparam int IDXW  = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW    = POS_W - TILE_SHIFT;

  typedef enum logic {IDLE, LOOK} state_t;

  state_t          state;
  logic [CW-1:0]   gnt;
  logic [CW-1:0]   last_grant;
  logic [TW-1:0]   tx;
  logic [TW-1:0]   ty;

  logic [NUM_CH-1:0] elig;
  logic              found;
  logic [CW-1:0]     gsel;
  logic [POS_W-1:0]  sx;
  logic [POS_W-1:0]  sy;
  logic [3:0]        nw;
  logic              noob;

  assign busy = (state == LOOK);

  // Pick the eligible channel closest after last_grant in rotation order.
  always_comb begin
    int best;
    int d;
    elig  = req & ~ack;
    found = 1'b0;
    gsel  = '0;
    sx    = '0;
    sy    = '0;
    best  = NUM_CH;
    d     = 0;
    for (int j = 0; j < NUM_CH; j++) begin
      d = (j + NUM_CH - 1 - int'(last_grant)) % NUM_CH;
      if (elig[j] && d < best) begin
        best  = d;
        found = 1'b1;
        gsel  = CW'(j);
        sx    = xPos[j*POS_W +: POS_W];
        sy    = yPos[j*POS_W +: POS_W];
      end
    end
  end

  // Neighbour read with boundary rules; range is checked before indexing.
  function automatic logic rd(input int col, input int row);
    int c;
    c = col;
    if (row < 0 || row >= MAP_H) return 1'b1;
`ifdef WALLQ_WRAP_EN
    if (c < 0) c = MAP_W - 1;
    else if (c >= MAP_W) c = 0;
`else
    if (c < 0 || c >= MAP_W) return 1'b1;
`endif
    return wallData[IDXW'(row * MAP_W + c)];
  endfunction

  always_comb begin
    int cx;
    int cy;
    cx   = int'(tx);
    cy   = int'(ty);
    nw   = 4'b1111;
    noob = 1'b1;
    if (cx < MAP_W && cy < MAP_H) begin
      noob = 1'b0;
      nw   = {rd(cx, cy - 1), rd(cx + 1, cy),
              rd(cx - 1, cy), rd(cx, cy + 1)};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      gnt        <= '0;
      last_grant <= CW'(NUM_CH - 1);
      tx         <= '0;
      ty         <= '0;
      ack        <= '0;
      walls      <= '1;
      oob        <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt        <= gsel;
            last_grant <= gsel;
            tx         <= TW'(sx >> TILE_SHIFT);
            ty         <= TW'(sy >> TILE_SHIFT);
            state      <= LOOK;
          end
        end
        LOOK: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (CW'(c) == gnt) begin
              walls[c*4 +: 4] <= nw;
              oob[c]          <= noob;
              ack[c]          <= 1'b1;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
